// File: rtl/lsu_bus_if.sv
// lsu_bus_if: valid/ready request and load-response channel between the LSU and the data memory port
interface lsu_bus_if;
  logic        valid;
  logic        ready;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        rvalid;
  logic [31:0] rdata;
  modport master (output valid, we, addr, wdata, wstrb, input ready, rvalid, rdata);
  modport slave  (input valid, we, addr, wdata, wstrb, output ready, rvalid, rdata);
endinterface

// File: rtl/lsu_bus_ctrl.sv
// lsu_bus_ctrl: memory-stage bus controller with alignment, width and timeout fault reporting
module lsu_bus_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic             req_we,
  input  logic [31:0]      req_addr,
  input  logic [2:0]       req_strb,
  input  logic [31:0]      req_wdata,
  input  logic [3:0]       req_wmask,
  output logic             stall,
  output logic             done,
  output logic             fault,
  output logic [1:0]       fault_cause,
  output logic [31:0]      rdata_raw,
  lsu_bus_if.master        bus
);
  localparam logic [1:0] IDLE = 2'd0, BUS_REQ = 2'd1, BUS_RESP = 2'd2, FINISH = 2'd3;
  logic [1:0] state, cause, chk_cause;
  logic [7:0] cnt;
  logic       is_byte, is_half, is_word, expired;
  assign is_byte   = req_strb[1:0] == 2'b00;
  assign is_half   = req_strb[1:0] == 2'b01;
  assign is_word   = req_strb == 3'b010;
  assign chk_cause = !(is_byte || is_half || is_word) ? 2'b11 :
                     ((is_half && req_addr[0]) || (is_word && req_addr[1:0] != 2'b00)) ? 2'b01 : 2'b00;
  assign expired   = cnt == 8'(TIMEOUT_CYCLES - 1);
  assign stall       = req_valid && state != FINISH;
  assign done        = state == FINISH;
  assign fault       = done && cause != 2'b00;
  assign fault_cause = done ? cause : 2'b00;
  assign bus.valid   = state == BUS_REQ;
  // a handshake on the expiring cycle takes priority over the timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cause     <= 2'b00;
      cnt       <= 8'd0;
      rdata_raw <= 32'd0;
      bus.we    <= 1'b0;
      bus.addr  <= 32'd0;
      bus.wdata <= 32'd0;
      bus.wstrb <= 4'd0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          cause <= chk_cause;
          cnt   <= 8'd0;
          state <= chk_cause != 2'b00 ? FINISH : BUS_REQ;
          if (chk_cause == 2'b00) begin
            bus.we    <= req_we;
            bus.addr  <= {req_addr[31:2], 2'b00};
            bus.wdata <= req_wdata;
            bus.wstrb <= req_we ? req_wmask : 4'd0;
          end
        end
        BUS_REQ: if (bus.ready) begin
          cnt   <= 8'd0;
          state <= bus.we ? FINISH : BUS_RESP;
        end else if (expired) begin
          cause <= 2'b10;
          state <= FINISH;
        end else cnt <= cnt + 8'd1;
        BUS_RESP: if (bus.rvalid) begin
          rdata_raw <= bus.rdata;
          state     <= FINISH;
        end else if (expired) begin
          cause <= 2'b10;
          state <= FINISH;
        end else cnt <= cnt + 8'd1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// tb_lsu_bus_ctrl: directed scoreboard bench; stimulus queues expectations, monitors pop and compare
module tb_lsu_bus_ctrl;
  typedef struct {logic f; logic [1:0] c; logic [31:0] rd; int dc; int vc; int fv;} resp_t;
  typedef struct {logic we; logic [31:0] a; logic [31:0] d; logic [3:0] s;} bus_t;
  logic        clk = 0, rst = 1;
  logic        req_valid = 0, req_we = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic [2:0]  req_strb = 0;
  logic [3:0]  req_wmask = 0;
  logic        stall, done, fault;
  logic [1:0]  fault_cause;
  logic [31:0] rdata_raw;
  lsu_bus_if bus ();
  lsu_bus_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_strb(req_strb), .req_wdata(req_wdata), .req_wmask(req_wmask), .stall(stall),
    .done(done), .fault(fault), .fault_cause(fault_cause), .rdata_raw(rdata_raw), .bus(bus.master)
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0, cyc = 0, vcyc = 0, fvc = 0;
  int rdy_dly = 0, rv_dly = 0, vcnt = 0, rcnt = 0;
  logic [31:0] rv_data = 0, exp_rd = 0;
  logic armed = 0, in_resp = 0, hs_load = 0;
  resp_t rq[$];
  bus_t  bq[$];
  always @(posedge clk) cyc++;
  function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, a, e, cyc);
    end
  endfunction
  function automatic void fail_now(string n);
    n_chk++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", n, cyc);
  endfunction
  // memory model: ready after rdy_dly valid cycles, rvalid rv_dly cycles into the response wait
  initial begin
    bus.ready = 0;
    bus.rvalid = 0;
    bus.rdata = 0;
  end
  always @(negedge clk) hs_load = bus.valid && bus.ready && !bus.we;
  always @(posedge clk) begin
    #2;
    if (bus.valid) begin
      bus.ready = vcnt >= rdy_dly;
      vcnt++;
    end else begin
      bus.ready = 0;
      vcnt = 0;
    end
    bus.rvalid = 0;
    if (hs_load) begin
      in_resp = 1;
      rcnt = 0;
    end
    if (in_resp) begin
      if (rcnt == rv_dly) begin
        bus.rvalid = 1;
        bus.rdata = rv_data;
        in_resp = 0;
      end
      rcnt++;
    end
  end
  always @(negedge clk) if (armed) begin
    resp_t e;
    bus_t b;
    if (rst) vcyc = 0;
    if (bus.valid) begin
      if (vcyc == 0) fvc = cyc;
      vcyc++;
    end
    if (bus.valid && bus.ready) begin
      if (bq.size() == 0) fail_now("bus_unexpected_handshake");
      else begin
        b = bq.pop_front();
        chk("bus_we", bus.we, b.we);
        chk("bus_addr", bus.addr, b.a);
        chk("bus_wdata", bus.wdata, b.d);
        chk("bus_wstrb", bus.wstrb, b.s);
      end
    end
    chk("stall", stall, req_valid && !done);
    if (!done) chk("fault_idle", {fault, fault_cause}, 3'b000);
    else if (rq.size() == 0) fail_now("done_unexpected");
    else begin
      e = rq.pop_front();
      chk("fault", fault, e.f);
      chk("fault_cause", fault_cause, e.c);
      chk("rdata_raw", rdata_raw, e.rd);
      chk("done_cycle", cyc, e.dc);
      chk("bus_valid_cycles", vcyc, e.vc);
      if (e.vc > 0) chk("bus_valid_first_cycle", fvc, e.fv);
      vcyc = 0;
    end
  end
  task automatic run(input logic we, input logic [31:0] a, input logic [2:0] s, input logic [31:0] d,
                     input logic [3:0] m, input int rdy, input int rvd, input logic [31:0] rvdat,
                     input logic [31:0] ea, input logic [3:0] ews, input logic [1:0] c,
                     input int lat, input int vc);
    resp_t e;
    bus_t b;
    int n = 0;
    rdy_dly = rdy;
    rv_dly = rvd;
    rv_data = rvdat;
    @(posedge clk);
    #1;
    req_valid = 1;
    req_we = we;
    req_addr = a;
    req_strb = s;
    req_wdata = d;
    req_wmask = m;
    if (c == 2'b00) begin
      b.we = we;
      b.a = ea;
      b.d = d;
      b.s = ews;
      bq.push_back(b);
      if (!we) exp_rd = rvdat;
    end
    e.f = c != 2'b00;
    e.c = c;
    e.rd = exp_rd;
    e.dc = cyc + lat;
    e.vc = vc;
    e.fv = cyc + 1;
    rq.push_back(e);
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 40);
    if (!done) fail_now("done_wait_expired");
  endtask
  task automatic drop();
    @(posedge clk);
    #1;
    req_valid = 0;
  endtask
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_done", done, 0);
    chk("rst_fault", {fault, fault_cause}, 0);
    chk("rst_rdata", rdata_raw, 0);
    chk("rst_bus_valid", bus.valid, 0);
    chk("rst_bus_payload", {bus.we, bus.wstrb, bus.addr ^ bus.wdata}, 0);
    chk("rst_bus_addr", bus.addr, 0);
    @(posedge clk);
    #1;
    rst = 0;
    armed = 1;
    run(1, 32'h100, 3'b010, 32'hDEADBEEF, 4'hF, 0, 0, 0, 32'h100, 4'hF, 2'b00, 2, 1);
    run(0, 32'h203, 3'b100, 32'hA5A5A5A5, 4'h1, 3, 2, 32'h11223344, 32'h200, 4'h0, 2'b00, 8, 4);
    run(0, 32'h101, 3'b001, 32'h0, 4'h3, 0, 0, 0, 0, 0, 2'b01, 1, 0);
    run(1, 32'h102, 3'b010, 32'h12345678, 4'hF, 0, 0, 0, 0, 0, 2'b01, 1, 0);
    run(0, 32'h100, 3'b011, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b11, 1, 0);
    run(1, 32'h000, 3'b111, 32'h0, 4'hF, 0, 0, 0, 0, 0, 2'b11, 1, 0);
    run(0, 32'h300, 3'b010, 32'h0, 4'h0, 255, 0, 0, 0, 0, 2'b10, 5, 4);
    run(0, 32'h306, 3'b101, 32'h0, 4'h0, 3, 0, 32'hCAFEF00D, 32'h304, 4'h0, 2'b00, 6, 4);
    drop();
    rdy_dly = 0;
    rv_dly = 3;
    rv_data = 32'h99999999;
    @(posedge clk);
    #1;
    req_valid = 1;
    req_we = 0;
    req_addr = 32'h400;
    req_strb = 3'b010;
    req_wdata = 32'h0;
    bq.push_back('{we: 1'b0, a: 32'h400, d: 32'h0, s: 4'h0});
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1;
    req_valid = 0;
    exp_rd = 0;
    @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    chk("midrst_bus_valid", bus.valid, 0);
    chk("midrst_done", done, 0);
    chk("midrst_rdata", rdata_raw, 0);
    repeat (6) @(negedge clk);
    chk("late_rvalid_rdata", rdata_raw, 0);
    run(1, 32'h42, 3'b001, 32'h12340000, 4'hC, 0, 0, 0, 32'h40, 4'hC, 2'b00, 2, 1);
    run(0, 32'h44, 3'b010, 32'h0, 4'h0, 0, 0, 32'h55AA55AA, 32'h44, 4'h0, 2'b00, 3, 1);
    drop();
    repeat (4) @(negedge clk);
    chk("resp_queue_left", rq.size(), 0);
    chk("bus_queue_left", bq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog expired (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end
endmodule
